// File: rtl/matrix_pkg.sv
// Shared constants, frame type and scan FSM states for the LED matrix scan driver.
// The S_BLANK state is present only when MATRIX_BLANK_EN is defined.
package matrix_pkg;

  localparam int ROWS = 16;
  localparam int COLS = 16;

  typedef logic [ROWS-1:0][COLS-1:0] pixel_frame_t;

`ifdef MATRIX_BLANK_EN
  typedef enum logic [1:0] {
    S_LATCH = 2'd0,
    S_DRIVE = 2'd1,
    S_BLANK = 2'd2
  } scan_state_t;
`else
  typedef enum logic [1:0] {
    S_LATCH = 2'd0,
    S_DRIVE = 2'd1
  } scan_state_t;
`endif

endpackage

// File: rtl/matrix_scan_driver_row_decoder.sv
// 4-to-16 one-hot row select; all-zero output while the enable is low.
module row_decoder (
  input  logic [3:0]  idx_i,
  input  logic        en_i,
  output logic [15:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/matrix_scan_driver.sv
// Row-multiplexed red/green LED matrix driver: snapshot a frame, then drive rows 0..15 in turn.
// Define MATRIX_BLANK_EN to insert BLANK dead cycles after every row (anti-ghosting).
module matrix_scan_driver
  import matrix_pkg::*;
#(
  parameter int DWELL = 1024,
  parameter int BLANK = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0][15:0]    RedPixels,
  input  logic [15:0][15:0]    GrnPixels,
  output logic [15:0]          RowSink,
  output logic [15:0]          RedDriver,
  output logic [15:0]          GrnDriver,
  output logic                 frame_start,
  output logic [1:0]           scan_state_o
);

  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
`ifdef MATRIX_BLANK_EN
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
`endif
  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

  // Handshake: none. Inputs are sampled only in S_LATCH; outputs are Moore and
  // forced to zero while reset is high.

  scan_state_t  state_q, state_d;
  logic [3:0]   row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  pixel_frame_t red_buf_q, grn_buf_q;
  logic         load_buf;
  logic         drive_en;

  assign load_buf = (state_q == S_LATCH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_LATCH;
      row_q     <= '0;
      cnt_q     <= '0;
      red_buf_q <= '0;
      grn_buf_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      if (load_buf) begin
        red_buf_q <= RedPixels;
        grn_buf_q <= GrnPixels;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      S_LATCH: begin
        state_d = S_DRIVE;
        row_d   = '0;
        cnt_d   = '0;
      end
      S_DRIVE: begin
        if (cnt_q == DWELL_LAST) begin
          cnt_d = '0;
`ifdef MATRIX_BLANK_EN
          state_d = S_BLANK;
`else
          if (row_q == LAST_ROW) begin
            state_d = S_LATCH;
            row_d   = '0;
          end else begin
            row_d = row_q + 4'd1;
          end
`endif
        end
      end
`ifdef MATRIX_BLANK_EN
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d = '0;
          if (row_q == LAST_ROW) begin
            state_d = S_LATCH;
            row_d   = '0;
          end else begin
            state_d = S_DRIVE;
            row_d   = row_q + 4'd1;
          end
        end
      end
`endif
      default: begin
        state_d = S_LATCH;
        row_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs come only from registered state/row/buffers, gated off during reset.
  assign drive_en    = !reset && (state_q == S_DRIVE);
  assign frame_start = !reset && (state_q == S_LATCH);

  row_decoder u_row_decoder (
    .idx_i    (row_q),
    .en_i     (drive_en),
    .onehot_o (RowSink)
  );

  always_comb begin
    RedDriver = '0;
    GrnDriver = '0;
    if (drive_en) begin
      RedDriver = red_buf_q[row_q];
      GrnDriver = grn_buf_q[row_q];
    end
  end

  assign scan_state_o = state_q;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Self-checking bench for matrix_scan_driver: per-cycle reference model feeding an expected queue.
// Follows MATRIX_BLANK_EN the same way the design does.
module tb_matrix_scan_driver;
  import matrix_pkg::*;

  localparam int DWELL = 4;
  localparam int BLANK = 2;
`ifdef MATRIX_BLANK_EN
  localparam int BLANK_EFF = BLANK;
`else
  localparam int BLANK_EFF = 0;
`endif
  localparam int SLOT   = DWELL + BLANK_EFF;
  localparam int PERIOD = 1 + 16 * SLOT;
  localparam int W      = 49;

  logic             clk;
  logic             reset;
  logic [15:0][15:0] RedPixels;
  logic [15:0][15:0] GrnPixels;
  logic [15:0]      RowSink;
  logic [15:0]      RedDriver;
  logic [15:0]      GrnDriver;
  logic             frame_start;
  logic [1:0]       scan_state;

  matrix_scan_driver #(.DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk          (clk),
    .reset        (reset),
    .RedPixels    (RedPixels),
    .GrnPixels    (GrnPixels),
    .RowSink      (RowSink),
    .RedDriver    (RedDriver),
    .GrnDriver    (GrnDriver),
    .frame_start  (frame_start),
    .scan_state_o (scan_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           n_vec;
  int           n_err;
  int           m_pos;
  int           cyc;
  pixel_frame_t snap_red, snap_grn;

  task automatic check_vec(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got fs=%0b row=%h red=%h grn=%h exp fs=%0b row=%h red=%h grn=%h",
               tag, cyc, got[48], got[47:32], got[31:16], got[15:0],
               exp[48], exp[47:32], exp[31:16], exp[15:0]);
    end
  endtask

  function automatic logic [W-1:0] model_out(input int pos);
    logic [W-1:0] v;
    int q, r, off;
    v = '0;
    if (pos == 0) begin
      v[48] = 1'b1;
    end else begin
      q   = pos - 1;
      r   = q / SLOT;
      off = q % SLOT;
      if (off < DWELL) begin
        v[47:32] = 16'(1) << r;
        v[31:16] = snap_red[r];
        v[15:0]  = snap_grn[r];
      end
    end
    return v;
  endfunction

  // driver: inputs for this cycle are already set; predict, sample at negedge, advance.
  task automatic tick();
    logic [W-1:0] e;
    if (reset) begin
      e     = '0;
      m_pos = 0;
    end else begin
      e = model_out(m_pos);
      if (m_pos == 0) begin
        snap_red = RedPixels;
        snap_grn = GrnPixels;
      end
      m_pos = (m_pos == PERIOD - 1) ? 0 : m_pos + 1;
    end
    exp_q.push_back(e);
    @(negedge clk);
    check_vec(reset ? "reset_out" : "scan_out",
              {frame_start, RowSink, RedDriver, GrnDriver}, exp_q.pop_front());
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic poke_random();
    int r;
    r = $urandom_range(15, 0);
    RedPixels[r] = 16'($urandom);
    r = $urandom_range(15, 0);
    GrnPixels[r] = 16'($urandom);
  endtask

  initial begin
    int target;
    int n;
    n_vec = 0;
    n_err = 0;
    m_pos = 0;
    cyc   = -3;
    snap_red = '0;
    snap_grn = '0;
    reset     = 1'b1;
    RedPixels = '0;
    GrnPixels = '0;
    @(posedge clk);
    #1;
    repeat (3) tick();

    reset        = 1'b0;
    RedPixels[0] = 16'hA5A5;
    GrnPixels[3] = 16'h00FF;
    for (int c = 0; c < 3 * PERIOD + 5; c++) begin
      if (c == 1 + 2 * SLOT) RedPixels[5] = 16'hFFFF;
      if (c >= 2 * PERIOD + 5 && (c % 7) == 0) poke_random();
      tick();
    end

    // run to the first cycle of row 7, then reset mid-row
    target = 1 + 7 * SLOT;
    n = 0;
    while (m_pos != target && n < PERIOD + 2) begin
      if ((n % 5) == 0) poke_random();
      tick();
      n++;
    end
    check_vec("row7_reach_timeout", {48'b0, (m_pos == target)}, {48'b0, 1'b1});
    tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    for (int c = 0; c < PERIOD + 10; c++) begin
      if ((c % 9) == 3) poke_random();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_scan_driver.md
MATRIX_SCAN_DRIVER -- requirements
Module: matrix_scan_driver

Interface
REQ-001 Parameter DWELL, default 1024, clock cycles each row is driven; legal range DWELL >= 1.
REQ-002 Parameter BLANK, default 16, blank cycles after each row; used only when MATRIX_BLANK_EN is defined; legal range BLANK >= 1.
REQ-003 Port clk  input  1  single clock for all logic.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port RedPixels  input  [15:0][15:0]  red frame from the game core, indexed [row][col]; row 0 is the top row.
REQ-006 Port GrnPixels  input  [15:0][15:0]  green frame from the game core, indexed the same way as RedPixels.
REQ-007 Port RowSink  output  16  active-high one-hot row select.
REQ-008 Port RedDriver  output  16  red column drive for the selected row.
REQ-009 Port GrnDriver  output  16  green column drive for the selected row.
REQ-010 Port frame_start  output  1  one-cycle pulse on each frame snapshot.

Function
REQ-011 The state machine SHALL have states S_LATCH, S_DRIVE and S_BLANK, where S_BLANK exists only when MATRIX_BLANK_EN is defined.
REQ-012 S_LATCH SHALL last one cycle and load the internal red and green buffers from RedPixels and GrnPixels, with frame_start=1 and RowSink, RedDriver and GrnDriver all zero.
REQ-013 S_DRIVE SHALL last exactly DWELL cycles, with RowSink=1<<row, RedDriver=red_buf[row] and GrnDriver=grn_buf[row].
REQ-014 The transition out of S_DRIVE without the macro SHALL be: if row<15, row increments and S_DRIVE continues; if row=15, row wraps to 0 and the next state is S_LATCH.
REQ-015 The transition out of S_DRIVE with the macro SHALL be to S_BLANK for BLANK cycles with all drive outputs zero, and then follow the same row-increment or wrap rule as REQ-014.
REQ-016 Outputs SHALL be Moore, decoded from registered state, row and buffers only, and SHALL never be decoded from the live inputs.
REQ-017 Changes on RedPixels or GrnPixels outside S_LATCH SHALL have no effect on outputs until the next S_LATCH.
REQ-018 The frame period SHALL be 1+16*DWELL cycles without the macro and 1+16*(DWELL+BLANK) cycles with it.
REQ-019 The dwell/blank counter SHALL be $clog2(max(DWELL,BLANK))+1 bits wide, count up from 0, and clear at every state or row change.
REQ-020 The row counter SHALL be 4 bits wide and wrap only through S_LATCH.
REQ-021 At most one RowSink bit SHALL be set in any cycle.

Reset
REQ-022 When reset=1 at a clock edge, the block SHALL set state to S_LATCH, row to 0, the counter to 0 and both buffers to zero, in every state.
REQ-023 While reset is held, RowSink, RedDriver, GrnDriver and frame_start SHALL all be 0.
REQ-024 The first cycle after reset deasserts SHALL be S_LATCH, with frame_start=1.
REQ-025 Reset SHALL take priority over every simultaneous transition.

Configuration
REQ-026 The macro MATRIX_BLANK_EN SHALL compile in the S_BLANK state and the BLANK parameter's effect, giving anti-ghosting dead time between rows.
REQ-027 Without MATRIX_BLANK_EN, S_BLANK logic SHALL be absent, BLANK SHALL be ignored, and rows SHALL be driven back-to-back.

Structure
REQ-028 Package matrix_pkg SHALL hold the constants ROWS=16 and COLS=16, typedef pixel_frame_t ([15:0][15:0] logic), and the state enum scan_state_t.
REQ-029 The 4-to-16 one-hot decode SHALL be implemented in one sub-module, row_decoder, with a 4-bit index input, an enable input and a 16-bit one-hot output that is zero when the enable is low.

Verification
REQ-030 Reset held for 3 cycles -> all outputs 0; first post-reset cycle (cycle 0) has frame_start=1 and RowSink=0; cycle 1 has RowSink=16'h0001. (DWELL=4, no macro for REQ-030 to REQ-034.)
REQ-031 RedPixels[0]=16'hA5A5 and GrnPixels[3]=16'h00FF, all else 0 -> cycles 1-4 RedDriver=16'hA5A5; cycles 13-16 RowSink=16'h0008 and GrnDriver=16'h00FF.
REQ-032 RedPixels[5] changed to 16'hFFFF during row 2 -> row 5 of the current frame shows the old value; the next frame shows 16'hFFFF.
REQ-033 Free run -> frame_start high at cycles 0, 65 and 130 and low at all other cycles; RowSink is 16'h8000 during cycles 61-64.
REQ-034 Reset asserted at row 7 -> outputs 0 on the next cycle; after release, S_LATCH runs and then row 0 is driven.
REQ-035 MATRIX_BLANK_EN with DWELL=4 and BLANK=2 -> frame period 97; cycles 5-6 have RowSink, RedDriver and GrnDriver all zero; row 1 is driven at cycles 7-10.
